uart_cmd_bridge: RTL and testbench

Hardware replacement for the soft-CPU housekeeping path. It parses the ASCII command stream from the UART receiver byte interface and drives a generic register bus directly, with no processor or ROM. Address width, data width, read latency, auto-increment and read-reply format are parameters. It sits between the uart_rx/uart_tx byte handshakes and the port register file.

---
 rtl/uart_cmd_bridge_pkg.sv | 40 ++++
 rtl/uart_cmd_bridge_tx_serializer.sv | 82 ++++++++
 rtl/uart_cmd_bridge.sv | 140 ++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_bridge_pkg.sv
// Shared types, ASCII constants and character helpers for the UART command bridge.
package uart_cmd_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    SEND
  } state_t;

  localparam logic [7:0] CH_M  = 8'h6d;
  localparam logic [7:0] CH_W  = 8'h77;
  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_LF = 8'h0a;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } nibble_t;

  // Lowercase ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nibble);
    if (nibble < 4'd10) hex_char = 8'h30 + {4'h0, nibble};
    else                hex_char = 8'h57 + {4'h0, nibble};
  endfunction

  // Decode '0'-'9', 'a'-'f', 'A'-'F'; valid is low for any other byte.
  function automatic nibble_t ascii_to_nibble(input logic [7:0] ch);
    nibble_t res;
    res.valid  = 1'b1;
    res.nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39)      res.nibble = ch[3:0];
    else if (ch >= 8'h61 && ch <= 8'h66) res.nibble = ch[3:0] + 4'd9;
    else if (ch >= 8'h41 && ch <= 8'h46) res.nibble = ch[3:0] + 4'd9;
    else                                 res.valid  = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/uart_cmd_bridge_tx_serializer.sv
// Turns one captured register word into a byte stream on the tx handshake:
// raw bytes MSB first, or lowercase hex digits MSB first followed by a line feed.
module bridge_tx_serializer
  import uart_cmd_bridge_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int HEX_OUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  localparam int NBYTES = (HEX_OUT != 0) ? DATA_W / 4 + 1 : DATA_W / 8;
  localparam int STEP   = (HEX_OUT != 0) ? 4 : 8;

  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [3:0]        left_reg, left_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              tx_valid_reg, tx_valid_next;
  logic [7:0]        top_byte;
  logic              handshake;

  // The byte currently at the head of the shift register.
  for (genvar gi = 0; gi < 8; gi++) begin : g_top
    assign top_byte[gi] = shift_reg[DATA_W-8+gi];
  end

  // Either the raw byte or the hex digit of its upper nibble.
  function automatic logic [7:0] emit(input logic [7:0] top);
    if (HEX_OUT != 0) emit = hex_char(top[7:4]);
    else              emit = top;
  endfunction

  assign handshake = tx_valid_reg & tx_ready;
  assign done      = handshake && (left_reg == 4'd0);
  assign tx_data   = tx_data_reg;
  assign tx_valid  = tx_valid_reg;

  // Load a new word or advance to the next byte after each accepted transfer.
  always_comb begin
    shift_next    = shift_reg;
    left_next     = left_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    if (load) begin
      tx_valid_next = 1'b1;
      tx_data_next  = emit(word[DATA_W-1 -: 8]);
      shift_next    = word << STEP;
      left_next     = 4'(NBYTES - 1);
    end else if (handshake) begin
      if (left_reg == 4'd0) begin
        tx_valid_next = 1'b0;
      end else begin
        left_next    = left_reg - 4'd1;
        tx_data_next = (HEX_OUT != 0 && left_reg == 4'd1) ? CH_LF : emit(top_byte);
        shift_next   = shift_reg << STEP;
      end
    end
  end

  // Serializer registers; reset drops any byte still pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg    <= '0;
      left_reg     <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
    end else begin
      shift_reg    <= shift_next;
      left_reg     <= left_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
    end
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// ASCII command parser driving a simple register bus: hex digits build an
// accumulator, 'm' sets the address, 'w' writes, 'r' reads and replies on tx.
module uart_cmd_bridge
  import uart_cmd_bridge_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int AUTO_INC = 0,
  parameter int HEX_OUT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              cmd_err
);

  localparam int ACC_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  state_t            state_reg, state_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              err_reg, err_next;
  logic [2:0]        wait_reg, wait_next;
  logic              ser_load;
  logic              ser_done;
  nibble_t           rx_nib;

  assign rx_nib    = ascii_to_nibble(rx_data);
  assign rx_ready  = reset && (state_reg == IDLE);
  assign reg_we    = reset && (state_reg == WRITE);
  assign reg_re    = reset && (state_reg == READ);
  assign reg_addr  = addr_reg;
  assign reg_wdata = wdata_reg;
  assign cmd_err   = err_reg;

  bridge_tx_serializer #(
    .DATA_W (DATA_W),
    .HEX_OUT(HEX_OUT)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (ser_load),
    .word    (reg_rdata),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .done    (ser_done)
  );

  // Command decode, bus sequencing and address bookkeeping.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    err_next   = 1'b0;
    wait_next  = wait_reg;
    ser_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rx_valid && rx_ready) begin
          if (rx_nib.valid) begin
            acc_next = {acc_reg[ACC_W-5:0], rx_nib.nibble};
          end else if (rx_data == CH_M) begin
            addr_next = acc_reg[ADDR_W-1:0];
            acc_next  = '0;
          end else if (rx_data == CH_W) begin
            wdata_next = acc_reg[DATA_W-1:0];
            acc_next   = '0;
            state_next = WRITE;
          end else if (rx_data == CH_R) begin
            state_next = READ;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      WRITE: begin
        if (AUTO_INC != 0) addr_next = addr_reg + ADDR_W'(1);
        state_next = IDLE;
      end
      READ: begin
        if (RD_LAT == 0) begin
          ser_load   = 1'b1;
          state_next = SEND;
        end else begin
          wait_next  = 3'(RD_LAT - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_reg == 3'd0) begin
          ser_load   = 1'b1;
          state_next = SEND;
        end else begin
          wait_next = wait_reg - 3'd1;
        end
      end
      SEND: begin
        if (ser_done) begin
          if (AUTO_INC != 0) addr_next = addr_reg + ADDR_W'(1);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
      wait_reg  <= wait_next;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Bench for uart_cmd_bridge: two configurations (raw 8-bit replies, and 16-bit
// hex replies with auto-increment and long read latency) driven by directed and
// random command bytes and compared against a command-level reference model.
module tb_uart_cmd_bridge;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sel = 1'b0;
  logic stall = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic tx_ready = 1'b0;
  logic [15:0] rd_drive = 16'h0000;

  logic a_rx_ready, a_tx_valid, a_we, a_re, a_err;
  logic [7:0] a_tx_data, a_addr, a_wdata;
  logic b_rx_ready, b_tx_valid, b_we, b_re, b_err;
  logic [7:0] b_tx_data, b_addr;
  logic [15:0] b_wdata;

  uart_cmd_bridge #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .AUTO_INC(0), .HEX_OUT(0)) dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & ~sel),
    .rx_ready(a_rx_ready), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(tx_ready & ~sel), .reg_addr(a_addr), .reg_wdata(a_wdata),
    .reg_we(a_we), .reg_re(a_re), .reg_rdata(rd_drive[7:0]), .cmd_err(a_err));

  uart_cmd_bridge #(.ADDR_W(8), .DATA_W(16), .RD_LAT(5), .AUTO_INC(1), .HEX_OUT(1)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid & sel),
    .rx_ready(b_rx_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(tx_ready & sel), .reg_addr(b_addr), .reg_wdata(b_wdata),
    .reg_we(b_we), .reg_re(b_re), .reg_rdata(rd_drive), .cmd_err(b_err));

  logic s_rx_ready, s_tx_valid, s_we, s_re, s_err;
  logic [7:0] s_tx_data, s_addr;
  logic [15:0] s_wdata;
  assign s_rx_ready = sel ? b_rx_ready : a_rx_ready;
  assign s_tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign s_tx_data  = sel ? b_tx_data  : a_tx_data;
  assign s_we       = sel ? b_we       : a_we;
  assign s_re       = sel ? b_re       : a_re;
  assign s_err      = sel ? b_err      : a_err;
  assign s_addr     = sel ? b_addr     : a_addr;
  assign s_wdata    = sel ? b_wdata    : {8'h00, a_wdata};

  always #5 clk = ~clk;

  // Sink readiness changes just after the rising edge, randomly unless stalled.
  always @(posedge clk) begin
    #1;
    tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Configuration of the currently selected DUT.
  int cfg_dw = 8;
  int cfg_lat = 1;
  bit cfg_auto = 1'b0;
  bit cfg_hex = 1'b0;

  // Environment: register file, read responder and event monitors.
  logic [15:0] regfile [256];
  logic [15:0] rd_word = 16'h0000;
  int rd_age = 100;
  logic [23:0] obs_wr[$];
  logic [7:0] obs_tx[$];
  int obs_re = 0;
  int obs_err = 0;
  logic hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      if (hold_pending) check("tx_hold", {s_tx_valid, s_tx_data}, {1'b1, hold_data});
      hold_pending = s_tx_valid && !tx_ready;
      hold_data = s_tx_data;
      if (s_we) begin
        regfile[s_addr] = s_wdata;
        obs_wr.push_back({s_addr, s_wdata});
      end
      if (s_re) begin
        rd_word = regfile[s_addr];
        rd_age = 0;
        obs_re++;
      end else if (rd_age < 100) begin
        rd_age++;
      end
      // Data is valid only in the cycle exactly RD_LAT after the strobe.
      rd_drive = (rd_age == cfg_lat) ? rd_word : ~rd_word;
      if (s_err) obs_err++;
      if (s_tx_valid && tx_ready) obs_tx.push_back(s_tx_data);
    end else begin
      hold_pending = 1'b0;
      rd_age = 100;
    end
  end

  // Reference model at command level.
  logic [15:0] model_mem [256];
  logic [15:0] m_acc = 16'h0000;
  logic [7:0] m_addr = 8'h00;
  logic [23:0] exp_wr[$];
  logic [7:0] exp_tx[$];
  int exp_re = 0;
  int exp_err = 0;

  function automatic logic [15:0] dmask();
    return 16'((32'h1 << cfg_dw) - 1);
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [15:0] d;
    int n;
    n = -1;
    if (b >= 8'h30 && b <= 8'h39) n = int'(b) - 48;
    else if (b >= 8'h61 && b <= 8'h66) n = int'(b) - 97 + 10;
    else if (b >= 8'h41 && b <= 8'h46) n = int'(b) - 65 + 10;
    if (n >= 0) begin
      // Accumulator is max(ADDR_W=8, DATA_W) bits; older digits fall off the top.
      m_acc = 16'((int'(m_acc) * 16 + n) % (1 << ((cfg_dw > 8) ? cfg_dw : 8)));
    end else if (b == 8'h6d) begin
      m_addr = m_acc[7:0];
      m_acc = 16'h0000;
    end else if (b == 8'h77) begin
      d = m_acc & dmask();
      exp_wr.push_back({m_addr, d});
      model_mem[m_addr] = d;
      m_acc = 16'h0000;
      if (cfg_auto) m_addr = m_addr + 8'd1;
    end else if (b == 8'h72) begin
      d = model_mem[m_addr];
      exp_re++;
      if (cfg_hex) begin
        for (int i = cfg_dw / 4 - 1; i >= 0; i--) begin
          int v;
          v = (int'(d) >> (4 * i)) % 16;
          exp_tx.push_back(v < 10 ? 8'(48 + v) : 8'(97 + v - 10));
        end
        exp_tx.push_back(8'h0a);
      end else begin
        for (int i = cfg_dw / 8 - 1; i >= 0; i--) exp_tx.push_back(8'(int'(d) >> (8 * i)));
      end
      if (cfg_auto) m_addr = m_addr + 8'd1;
    end else begin
      exp_err++;
    end
  endtask

  task automatic init_mem();
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom) & dmask();
      regfile[i] = v;
      model_mem[i] = v;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!s_rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept", s_rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_rx_ready && n < 1000);
    #1;
    check("idle", s_rx_ready, 1);
  endtask

  task automatic compare_events(input logic [7:0] b);
    $display("dut=%s byte=%02h addr=%02h writes=%0d tx_bytes=%0d reads=%0d errs=%0d",
             sel ? "B" : "A", b, s_addr, obs_wr.size(), obs_tx.size(), obs_re, obs_err);
    check("wr_count", obs_wr.size(), exp_wr.size());
    while (obs_wr.size() > 0 && exp_wr.size() > 0) check("wr_addr_data", obs_wr.pop_front(), exp_wr.pop_front());
    check("tx_count", obs_tx.size(), exp_tx.size());
    while (obs_tx.size() > 0 && exp_tx.size() > 0) check("tx_byte", obs_tx.pop_front(), exp_tx.pop_front());
    check("re_count", obs_re, exp_re);
    check("err_count", obs_err, exp_err);
    check("reg_addr", s_addr, m_addr);
    obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
    obs_re = 0; exp_re = 0; obs_err = 0; exp_err = 0;
  endtask

  task automatic do_byte(input logic [7:0] b);
    model_byte(b);
    send_byte(b);
    wait_idle();
    compare_events(b);
  endtask

  task automatic do_str(input string s);
    for (int i = 0; i < s.len(); i++) do_byte(s[i]);
  endtask

  task automatic random_run(input int count);
    string hexchars;
    string others;
    int r;
    logic [7:0] b;
    hexchars = "0123456789abcdefABCDEF";
    others = " zQMWRg\n";
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = hexchars[$urandom_range(0, hexchars.len() - 1)];
      else if (r < 65) b = 8'h6d;
      else if (r < 76) b = 8'h77;
      else if (r < 90) b = 8'h72;
      else             b = others[$urandom_range(0, others.len() - 1)];
      do_byte(b);
    end
  endtask

  initial begin
    int n;
    logic [7:0] held;
    // Reset values on both instances.
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_rx_ready", a_rx_ready, 0);
    check("rst_a_outs", {a_tx_valid, a_we, a_re, a_err}, 0);
    check("rst_a_addr", a_addr, 0);
    check("rst_a_wdata", a_wdata, 0);
    check("rst_a_tx_data", a_tx_data, 0);
    check("rst_b_rx_ready", b_rx_ready, 0);
    check("rst_b_outs", {b_tx_valid, b_we, b_re, b_err}, 0);
    check("rst_b_addr_wdata", {b_addr, b_wdata}, 0);
    reset = 1'b1;

    // Configuration A: 8-bit data, RD_LAT=1, raw reply, no auto-increment.
    sel = 1'b0; cfg_dw = 8; cfg_lat = 1; cfg_auto = 1'b0; cfg_hex = 1'b0;
    m_acc = 16'h0000; m_addr = 8'h00;
    init_mem();
    regfile[8'h10] = 16'h00a5; model_mem[8'h10] = 16'h00a5;
    do_str("2am5cw");
    do_str("10mr");
    do_str("123m");
    do_str("1z2m");
    random_run(150);
    wait_idle();

    // Configuration B: 16-bit data, RD_LAT=5, hex reply, auto-increment.
    sel = 1'b1; cfg_dw = 16; cfg_lat = 5; cfg_auto = 1'b1; cfg_hex = 1'b1;
    m_acc = 16'h0000; m_addr = 8'h00;
    init_mem();
    regfile[8'h10] = 16'h00a5; model_mem[8'h10] = 16'h00a5;
    do_str("ffm01w");
    do_str("1234w");
    do_str("10mr");
    do_str("fm1");

    // Stall the reply for 20 cycles with a byte queued on rx.
    stall = 1'b1;
    model_byte(8'h72);
    send_byte(8'h72);
    n = 0;
    while (!s_tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_tx_valid_seen", s_tx_valid, 1);
    held = s_tx_data;
    rx_data = 8'h37;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("stall_tx_valid", s_tx_valid, 1);
      check("stall_tx_data", s_tx_data, held);
      check("stall_rx_ready", s_rx_ready, 0);
    end
    stall = 1'b0;
    n = 0;
    while (!s_rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("reply_done_before_rx", obs_tx.size(), exp_tx.size());
    compare_events(8'h72);
    model_byte(8'h37);
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle();
    compare_events(8'h37);

    // Reset while waiting for read data.
    do_str("5am77w");
    send_byte(8'h72);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_rx_ready", b_rx_ready, 0);
    check("rst_mid_outs", {b_tx_valid, b_we, b_re, b_err}, 0);
    check("rst_mid_addr", b_addr, 0);
    check("rst_mid_wdata", b_wdata, 0);
    check("rst_mid_tx_data", b_tx_data, 0);
    reset = 1'b1;
    m_acc = 16'h0000; m_addr = 8'h00;
    obs_wr.delete(); obs_re = 0; obs_err = 0;
    repeat (12) @(negedge clk);
    #1;
    check("rst_no_tx", obs_tx.size(), 0);
    obs_tx.delete();
    do_str("r");
    random_run(120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
